// File: rtl/fetch_pc_unit.sv
// PC / IR stage of the multicycle CPU: holds PC, IR, MDR and ALUOut, drives the
// unified-memory address and strobes, and decodes the instruction fields.
module fetch_pc_unit #(
  parameter int unsigned DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pcWrite,
  input  logic              pcCond,
  input  logic [1:0]        pcSrc,
  input  logic              irWrite,
  input  logic              memSrc,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [DATA_W-1:0] aluResult,
  input  logic              zero,
  input  logic [DATA_W-1:0] memRdata,
  output logic [DATA_W-1:0] memAddr,
  output logic              memRe,
  output logic              memWe,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [5:0]        funct,
  output logic [15:0]       imm,
  output logic [DATA_W-1:0] mdr,
  output logic [DATA_W-1:0] aluOut,
  output logic [CNT_W-1:0]  instrCount,
  output logic              misaligned
);

  typedef enum logic [1:0] {
    SRC_ALU    = 2'b00,
    SRC_ALUOUT = 2'b01,
    SRC_JUMP   = 2'b10,
    SRC_RSVD   = 2'b11
  } pc_src_e;

  logic              pc_en;
  logic              pc_load;
  logic [DATA_W-1:0] pc_next;
  logic              mis_set;

  assign memAddr = memSrc ? aluOut : pc;
  assign memRe   = memRead;
  assign memWe   = memWrite;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign imm    = ir[15:0];

  assign pc_en = pcWrite | (pcCond & zero);

  // The reserved select leaves the PC untouched and must not raise the flag.
  always_comb begin
    pc_next = pc;
    pc_load = 1'b0;
    if (pc_en) begin
      case (pc_src_e'(pcSrc))
        SRC_ALU: begin
          pc_next = aluResult;
          pc_load = 1'b1;
        end
        SRC_ALUOUT: begin
          pc_next = aluOut;
          pc_load = 1'b1;
        end
        SRC_JUMP: begin
          pc_next = {pc[DATA_W-1:28], ir[25:0], 2'b00};
          pc_load = 1'b1;
        end
        default: begin
          pc_next = pc;
          pc_load = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mis_set = 1'b0;
    if ((memRead | memWrite) && (memAddr[1:0] != 2'b00))
      mis_set = 1'b1;
    if (pc_load && (pc_next[1:0] != 2'b00))
      mis_set = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= RESET_PC;
      ir         <= '0;
      mdr        <= '0;
      aluOut     <= '0;
      instrCount <= '0;
      misaligned <= 1'b0;
    end else begin
      aluOut <= aluResult;
      mdr    <= memRdata;
      if (pc_load)
        pc <= pc_next;
      if (irWrite) begin
        ir         <= memRdata;
        instrCount <= instrCount + 1'b1;
      end
      if (mis_set)
        misaligned <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; a narrow counter keeps the wrap check short.
module tb_fetch_pc_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          pcWrite, pcCond, irWrite, memSrc, memRead, memWrite, zero;
  logic [1:0]    pcSrc;
  logic [DW-1:0] aluResult, memRdata;
  logic [DW-1:0] memAddr, pc, ir, mdr, aluOut;
  logic          memRe, memWe, misaligned;
  logic [5:0]    opcode, funct;
  logic [4:0]    rs, rt, rd;
  logic [15:0]   imm;
  logic [CW-1:0] instrCount;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_pc_unit #(.DATA_W(DW), .RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .pcWrite(pcWrite), .pcCond(pcCond), .pcSrc(pcSrc),
    .irWrite(irWrite), .memSrc(memSrc), .memRead(memRead), .memWrite(memWrite),
    .aluResult(aluResult), .zero(zero), .memRdata(memRdata), .memAddr(memAddr),
    .memRe(memRe), .memWe(memWe), .pc(pc), .ir(ir), .opcode(opcode), .rs(rs),
    .rt(rt), .rd(rd), .funct(funct), .imm(imm), .mdr(mdr), .aluOut(aluOut),
    .instrCount(instrCount), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pcWrite = 0; pcCond = 0; pcSrc = 2'b00; irWrite = 0;
    memSrc = 0; memRead = 0; memWrite = 0; zero = 0;
  endtask

  initial begin
    idle();
    reset = 0; aluResult = '0; memRdata = 32'hFFFF_FFFF;
    memRead = 1;
    step(); step();
    check("rst_pc", pc, 32'h0);
    check("rst_ir", ir, 32'h0);
    check("rst_cnt", 32'(instrCount), 32'h0);
    check("rst_mis", 32'(misaligned), 32'h0);
    check("rst_mdr", mdr, 32'h0);
    check("rst_memRe_pass", 32'(memRe), 32'h1);
    memRead = 0;
    reset = 1; memRdata = '0;
    step();
    check("hold_pc", pc, 32'h0);
    check("hold_ir", ir, 32'h0);

    // fetch
    memRdata = 32'h2002_0005; aluResult = 32'h4; pcWrite = 1; irWrite = 1;
    #1 check("fetch_addr", memAddr, 32'h0);
    step();
    check("fetch_pc", pc, 32'h4);
    check("fetch_ir", ir, 32'h2002_0005);
    check("fetch_opcode", 32'(opcode), 32'h08);
    check("fetch_rt", 32'(rt), 32'h2);
    check("fetch_imm", 32'(imm), 32'h5);
    check("fetch_cnt", 32'(instrCount), 32'h1);
    check("fetch_aluOut", aluOut, 32'h4);
    idle();

    // branch
    aluResult = 32'h40;
    step();
    check("br_aluOut", aluOut, 32'h40);
    pcCond = 1; pcSrc = 2'b01; zero = 1; aluResult = 32'h0;
    step();
    check("br_taken", pc, 32'h40);
    zero = 0; aluResult = 32'h80;
    step();
    check("br_not_taken", pc, 32'h40);
    pcWrite = 1;
    step();
    check("br_pcwrite_dom", pc, 32'h80);
    idle();

    // jump
    memRdata = 32'hFC00_0010; aluResult = 32'h1000_0008; pcWrite = 1; irWrite = 1;
    step();
    check("j_pc0", pc, 32'h1000_0008);
    check("j_opcode", 32'(opcode), 32'h3F);
    check("j_cnt", 32'(instrCount), 32'h2);
    irWrite = 0; pcSrc = 2'b10;
    step();
    check("j_pc", pc, 32'h1000_0040);
    pcSrc = 2'b11; aluResult = 32'h3;
    step();
    check("rsvd_pc", pc, 32'h1000_0040);
    check("rsvd_mis", 32'(misaligned), 32'h0);
    idle();

    // load / store path
    aluResult = 32'h84;
    step();
    memSrc = 1; memRead = 1; memRdata = 32'hDEAD_BEEF; aluResult = 32'h86;
    #1;
    check("ld_addr", memAddr, 32'h84);
    check("ld_re", 32'(memRe), 32'h1);
    step();
    check("ld_mdr", mdr, 32'hDEAD_BEEF);
    check("ld_mis_clear", 32'(misaligned), 32'h0);
    check("ld_addr86", memAddr, 32'h86);
    step();
    check("ld_mis_set", 32'(misaligned), 32'h1);
    memRead = 0; memSrc = 0; memWrite = 1;
    #1 check("st_we", 32'(memWe), 32'h1);
    memWrite = 0;
    step();
    check("mis_sticky", 32'(misaligned), 32'h1);

    // async reset mid-cycle
    pcWrite = 1; pcSrc = 2'b00; aluResult = 32'h40;
    step();
    check("pre_rst_pc", pc, 32'h40);
    idle();
    #2 reset = 0;
    #1;
    check("async_pc", pc, 32'h0);
    check("async_mis", 32'(misaligned), 32'h0);
    check("async_cnt", 32'(instrCount), 32'h0);
    step();
    reset = 1;

    // misaligned from PC write
    pcWrite = 1; aluResult = 32'h6;
    step();
    check("pcmis_pc", pc, 32'h6);
    check("pcmis_flag", 32'(misaligned), 32'h1);
    idle();
    #2 reset = 0;
    #1 reset = 1;

    // counter wrap
    irWrite = 1; memRdata = 32'h0;
    for (int i = 0; i < 15; i++) step();
    check("cnt_max", 32'(instrCount), 32'hF);
    step();
    check("cnt_wrap", 32'(instrCount), 32'h0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program-counter / instruction-register stage of the multicycle CPU. Sits between unified memory and the main control FSM.
- Holds PC, IR, MDR and ALUOut. Drives the memory address and strobes. Supplies `opcode` and the decoded instruction fields to the control unit and datapath.
- Consumes the control unit's pcWrite, pcCond, pcSrc, irWrite, memSrc, memRead and memWrite outputs.

Parameters:
- DATA_W, 32, datapath / instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- pcWrite  in  1  unconditional PC write.
- pcCond  in  1  conditional PC write, taken when zero=1.
- pcSrc  in  2  next-PC select.
- irWrite  in  1  load IR from memRdata.
- memSrc  in  1  memory address select: 0 = PC, 1 = ALUOut.
- memRead  in  1  read strobe from the control unit.
- memWrite  in  1  write strobe from the control unit.
- aluResult  in  DATA_W  combinational ALU output.
- zero  in  1  ALU zero flag.
- memRdata  in  DATA_W  memory read data, combinational (valid in the same cycle as memAddr/memRe).
- memAddr  out  DATA_W  memory address.
- memRe  out  1  memory read enable.
- memWe  out  1  memory write enable.
- pc  out  DATA_W  current PC.
- ir  out  DATA_W  instruction register.
- opcode  out  6  ir[31:26]; feeds the control unit.
- rs, rt, rd  out  5 each  ir[25:21], ir[20:16], ir[15:11].
- funct  out  6  ir[5:0].
- imm  out  16  ir[15:0].
- mdr  out  DATA_W  memory data register.
- aluOut  out  DATA_W  ALUOut register.
- instrCount  out  CNT_W  number of instructions fetched.
- misaligned  out  1  sticky flag: access to an address with nonzero [1:0].

Behaviour:
- Reset (reset=0, asynchronous):
  - pc = RESET_PC.
  - ir, mdr, aluOut, instrCount = 0.
  - misaligned = 0.
  - Reset asserted mid-instruction discards all in-flight state immediately, with no clock edge required.
  - Registers hold reset values while reset=0. Normal operation resumes on the first rising edge after deassertion.
- Combinational outputs:
  - memAddr = memSrc ? aluOut : pc.
  - memRe = memRead; memWe = memWrite. These pass through unchanged, including during reset.
  - opcode and the instruction fields are decoded from the registered ir. They change only the cycle after an IR load.
- ALUOut and MDR:
  - aluOut <= aluResult on every rising edge; no enable.
  - mdr <= memRdata on every rising edge.
- IR load: when irWrite=1, ir <= memRdata and instrCount <= instrCount+1. The counter wraps modulo 2^CNT_W.
- PC update:
  - pcEn = pcWrite | (pcCond & zero). pcWrite dominates if both are asserted.
  - When pcEn=1, the next PC is selected by pcSrc:
    - 00: aluResult (PC+4 during fetch).
    - 01: aluOut (branch target computed in the decode state).
    - 10: {pc[31:28], ir[25:0], 2'b00} (jump).
    - 11: reserved; PC holds and no flag is raised.
  - pcCond=1 with zero=0: PC holds.
- Fetch cycle: pcWrite=1, irWrite=1, memSrc=0 in the same cycle. IR captures the word at the old pc; PC takes the new value on the same edge.
- Latency:
  - IR contents are visible on opcode one cycle after the fetch state.
  - A PC update is visible on pc the cycle after pcEn.
- misaligned:
  - Set on any edge where (memRead | memWrite) = 1 and memAddr[1:0] != 0.
  - Also set when a PC write loads a value with [1:0] != 0.
  - Cleared only by reset. It does not block the access; the flag is reporting only.

Test Plan:
1. Reset: drive reset=0 with memRdata=32'hFFFF_FFFF and toggle clk -> pc=0, ir=0, instrCount=0, misaligned=0. Deassert reset -> values hold until stimulus arrives.
2. Fetch: pc=0, memRdata=32'h2002_0005, aluResult=4, pcWrite=1, irWrite=1, pcSrc=00 -> next cycle pc=4, ir=32'h2002_0005, opcode=6'b001000, instrCount=1.
3. Branch: aluResult=32'h40 latched into aluOut, then pcCond=1, pcSrc=01:
   - zero=1 -> pc=32'h40.
   - zero=0 -> pc unchanged.
   - pcWrite=1 with pcCond=1, zero=0 -> PC written.
4. Jump: pc=32'h1000_0008, ir=32'hFC00_0010, pcWrite=1, pcSrc=10 -> pc=32'h1000_0040.
5. Load/store path: aluResult=32'h84 latched, then memSrc=1, memRead=1 -> memAddr=32'h84, memRe=1; next edge mdr=memRdata. Same with aluResult=32'h86 -> misaligned=1 and stays 1 until reset.
6. Async reset mid-operation: assert reset=0 between clock edges while pc=32'h40 -> pc=0 immediately, without a clock edge. Counter wrap: instrCount=32'hFFFF_FFFF plus one IR load -> 0.
